peak_filter: RTL

- Tone-shaping stage that sits directly downstream of the distortion gain stage. It consumes the boosted 24-bit signed sample and produces the filtered sample sent to the output path.
- Implements one Direct Form I biquad, y = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2, using a single time-shared multiplier driven by a small state machine.
- Coefficients are supplied by the control logic and are captured once per sample.

---
 rtl/peak_filter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/peak_filter.sv
// +--------------------------------------------------------------------------+
// | peak_filter: Direct Form I biquad on one time-shared multiplier.          |
// | Optional PEAK_FILTER_SAT_COUNT_EN adds the Sat_Count clip counter port.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module peak_filter #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = 44
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] D_Boosted,
  input  logic              Sample_Valid,
  input  logic [COEF_W-1:0] B0,
  input  logic [COEF_W-1:0] B1,
  input  logic [COEF_W-1:0] B2,
  input  logic [COEF_W-1:0] A1,
  input  logic [COEF_W-1:0] A2,
  input  logic              Bypass,
  output logic [DATA_W-1:0] D_Filtered,
  output logic              Out_Valid,
  output logic              Busy,
  output logic              Overrun
`ifdef PEAK_FILTER_SAT_COUNT_EN
  ,
  output logic [15:0]       Sat_Count
`endif
);

  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] LAST_TAP = 3'd4;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_POS  = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_NEG  = -SAT_POS;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] tap;

  logic capture;
  logic mac_en;
  logic done_en;

  logic signed [DATA_W-1:0] x0;
  logic signed [DATA_W-1:0] x1;
  logic signed [DATA_W-1:0] x2;
  logic signed [DATA_W-1:0] y1;
  logic signed [DATA_W-1:0] y2;
  logic signed [COEF_W-1:0] coef_b0;
  logic signed [COEF_W-1:0] coef_b1;
  logic signed [COEF_W-1:0] coef_b2;
  logic signed [COEF_W-1:0] coef_a1;
  logic signed [COEF_W-1:0] coef_a2;
  logic                     byp_q;
  logic signed [ACC_W-1:0]  acc;

  logic signed [DATA_W-1:0] op_x;
  logic signed [COEF_W-1:0] op_c;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  rnd_q;
  logic signed [DATA_W-1:0] sat_val;
  logic                     clipped;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Sample_Valid) state_nxt = S_MAC;
      S_MAC:   if (tap == LAST_TAP) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capture = (state == S_IDLE) && Sample_Valid;
    mac_en  = (state == S_MAC);
    done_en = (state == S_DONE);
    Busy    = (state != S_IDLE);
  end

  // ---------------------------------------------------------------- MAC
  always_comb begin
    op_x = x0;
    op_c = coef_b0;
    case (tap)
      3'd1: begin op_x = x1; op_c = coef_b1; end
      3'd2: begin op_x = x2; op_c = coef_b2; end
      3'd3: begin op_x = y1; op_c = coef_a1; end
      3'd4: begin op_x = y2; op_c = coef_a2; end
      default: ;
    endcase
  end

  assign prod     = PROD_W'(op_x) * PROD_W'(op_c);
  assign prod_ext = ACC_W'(prod);

  // Round half toward +inf, then clip symmetrically so -full-scale never appears.
  assign rnd_sum = acc + RND_HALF;
  assign rnd_q   = rnd_sum >>> COEF_FRAC;

  always_comb begin
    clipped = 1'b0;
    sat_val = rnd_q[DATA_W-1:0];
    if (rnd_q > SAT_POS) begin
      clipped = 1'b1;
      sat_val = SAT_POS[DATA_W-1:0];
    end else if (rnd_q < SAT_NEG) begin
      clipped = 1'b1;
      sat_val = SAT_NEG[DATA_W-1:0];
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x0         <= '0;
      x1         <= '0;
      x2         <= '0;
      y1         <= '0;
      y2         <= '0;
      coef_b0    <= '0;
      coef_b1    <= '0;
      coef_b2    <= '0;
      coef_a1    <= '0;
      coef_a2    <= '0;
      byp_q      <= 1'b0;
      acc        <= '0;
      tap        <= '0;
      D_Filtered <= '0;
      Out_Valid  <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      Out_Valid <= 1'b0;
      if (capture) begin
        x0      <= D_Boosted;
        coef_b0 <= B0;
        coef_b1 <= B1;
        coef_b2 <= B2;
        coef_a1 <= A1;
        coef_a2 <= A2;
        byp_q   <= Bypass;
        acc     <= '0;
        tap     <= '0;
      end
      // Feedback taps (k=3,4) are subtracted.
      if (mac_en) begin
        acc <= (tap >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);
        tap <= tap + 3'd1;
      end
      if (done_en) begin
        x2         <= x1;
        x1         <= x0;
        y2         <= y1;
        y1         <= sat_val;
        D_Filtered <= byp_q ? x0 : sat_val;
        Out_Valid  <= 1'b1;
      end
      if (Sample_Valid && Busy) begin
        Overrun <= 1'b1;
      end
    end
  end

`ifdef PEAK_FILTER_SAT_COUNT_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Sat_Count <= '0;
    end else if (done_en && clipped && (Sat_Count != 16'hFFFF)) begin
      Sat_Count <= Sat_Count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
